// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter and its result queues.
package cdb_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_W_DEF = 5;
    localparam int DEPTH_DEF = 4;

    // Identifies a result source; also used for the round-robin last-grant register.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue: power-of-two ring buffer with flush, exposing head, count and full.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int WIDTH = DATA_W + ROB_W_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are PTR_W bits wide, so increment wraps modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define validity,
    // and leaving the array out of reset lets it map onto plain RAM/flops without reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between ALU and LSB results onto a registered common data bus,
// with a per-source queue absorbing the losing source and a sticky overflow flag.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              wrong_commit,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [ROB_W-1:0]  alu_rob_id,
    input  logic              lsb_valid,
    input  logic [DATA_W-1:0] lsb_res,
    input  logic [ROB_W-1:0]  lsb_rob_id,
    output logic              alu_stall,
    output logic              lsb_stall,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_res,
    output logic [ROB_W-1:0]  cdb_rob_id,
    output logic              overflow_err
);

    localparam int ENTRY_W = DATA_W + ROB_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               en;
    logic               alu_live, lsb_live;
    logic               alu_has_q, lsb_has_q;
    logic               alu_cand, lsb_cand;
    logic [ENTRY_W-1:0] alu_head, lsb_head;
    logic [ENTRY_W-1:0] alu_cand_data, lsb_cand_data;
    logic [CNT_W-1:0]   alu_count, lsb_count;
    logic               alu_full, lsb_full;
    logic               alu_push, lsb_push;
    logic               alu_pop, lsb_pop;
    logic               alu_win, lsb_win;
    logic               grant_valid;
    src_e               grant_src;
    src_e               last_grant;
    logic [ENTRY_W-1:0] win_data;
    logic               drop;

    // A misprediction flush overrides any same-cycle offer.
    assign en = rdy && !wrong_commit;

    assign alu_live  = alu_valid && (alu_rob_id != '0);
    assign lsb_live  = lsb_valid && (lsb_rob_id != '0);
    assign alu_has_q = (alu_count != '0);
    assign lsb_has_q = (lsb_count != '0);
    assign alu_cand  = alu_has_q || alu_live;
    assign lsb_cand  = lsb_has_q || lsb_live;

    assign alu_cand_data = alu_has_q ? alu_head : {alu_res, alu_rob_id};
    assign lsb_cand_data = lsb_has_q ? lsb_head : {lsb_res, lsb_rob_id};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_ALU;
        if (alu_cand && lsb_cand) begin
            grant_valid = 1'b1;
            grant_src   = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (alu_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ALU;
        end else if (lsb_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSB;
        end
    end

    assign alu_win  = grant_valid && (grant_src == SRC_ALU);
    assign lsb_win  = grant_valid && (grant_src == SRC_LSB);
    assign win_data = (grant_src == SRC_ALU) ? alu_cand_data : lsb_cand_data;

    // A winning live offer bypasses its empty queue; every other live offer is queued.
    assign alu_pop  = en && alu_win && alu_has_q;
    assign lsb_pop  = en && lsb_win && lsb_has_q;
    assign alu_push = en && alu_live && !(alu_win && !alu_has_q);
    assign lsb_push = en && lsb_live && !(lsb_win && !lsb_has_q);

    assign drop = (alu_push && alu_full && !alu_pop) || (lsb_push && lsb_full && !lsb_pop);

    assign alu_stall = (alu_count >= CNT_W'(DEPTH - 1));
    assign lsb_stall = (lsb_count >= CNT_W'(DEPTH - 1));

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .pop       (alu_pop),
        .flush     (wrong_commit),
        .push_data ({alu_res, alu_rob_id}),
        .head      (alu_head),
        .count     (alu_count),
        .full      (alu_full)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsb_push),
        .pop       (lsb_pop),
        .flush     (wrong_commit),
        .push_data ({lsb_res, lsb_rob_id}),
        .head      (lsb_head),
        .count     (lsb_count),
        .full      (lsb_full)
    );

    // last_grant holds the source granted most recently; SRC_LSB gives the ALU priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid    <= 1'b0;
            cdb_res      <= '0;
            cdb_rob_id   <= '0;
            overflow_err <= 1'b0;
            last_grant   <= SRC_LSB;
        end else if (wrong_commit) begin
            cdb_valid  <= 1'b0;
            last_grant <= SRC_LSB;
        end else if (rdy) begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                {cdb_res, cdb_rob_id} <= win_data;
                last_grant            <= grant_src;
            end
            if (drop) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: single-offer vector table plus scoreboarded contention, overflow,
// flush, stall-hold and reset sequences.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int ROB_W = 5;

    logic              clk = 1'b0;
    logic              rst, rdy, wrong_commit;
    logic              alu_valid, lsb_valid;
    logic [DATA_W-1:0] alu_res, lsb_res;
    logic [ROB_W-1:0]  alu_rob_id, lsb_rob_id;
    logic              alu_stall, lsb_stall;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_res;
    logic [ROB_W-1:0]  cdb_rob_id;
    logic              overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic              av;
        logic [ROB_W-1:0]  aid;
        logic [DATA_W-1:0] ares;
        logic              lv;
        logic [ROB_W-1:0]  lid;
        logic [DATA_W-1:0] lres;
        logic              e1v;
        logic [ROB_W-1:0]  e1id;
        logic [DATA_W-1:0] e1res;
        logic [2:0]        e1lc;
        logic              e2v;
        logic [ROB_W-1:0]  e2id;
        logic [DATA_W-1:0] e2res;
    } vec_t;

    typedef struct {
        logic [ROB_W-1:0]  id;
        logic [DATA_W-1:0] res;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    always #5 clk = ~clk;

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .wrong_commit (wrong_commit),
        .alu_valid    (alu_valid),
        .alu_res      (alu_res),
        .alu_rob_id   (alu_rob_id),
        .lsb_valid    (lsb_valid),
        .lsb_res      (lsb_res),
        .lsb_rob_id   (lsb_rob_id),
        .alu_stall    (alu_stall),
        .lsb_stall    (lsb_stall),
        .cdb_valid    (cdb_valid),
        .cdb_res      (cdb_res),
        .cdb_rob_id   (cdb_rob_id),
        .overflow_err (overflow_err)
    );

    function automatic logic [DATA_W-1:0] a_res(input int k);
        return 32'hA000_0000 | DATA_W'(k);
    endfunction

    function automatic logic [DATA_W-1:0] l_res(input int k);
        return 32'hB000_0000 | DATA_W'(k);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input int aid, input logic [DATA_W-1:0] ares,
                         input logic lv, input int lid, input logic [DATA_W-1:0] lres);
        alu_valid  = av;
        alu_rob_id = ROB_W'(aid);
        alu_res    = ares;
        lsb_valid  = lv;
        lsb_rob_id = ROB_W'(lid);
        lsb_res    = lres;
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic expect_bcast(input int id, input logic [DATA_W-1:0] res);
        exp_t e;
        e.id  = ROB_W'(id);
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic observe(input string tag);
        exp_t e;
        if (cdb_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_extra: got broadcast id %0d res %0h, expected none", tag, cdb_rob_id, cdb_res);
            end else begin
                e = sb.pop_front();
                check({tag, "_id"}, 64'(cdb_rob_id), 64'(e.id));
                check({tag, "_res"}, 64'(cdb_res), 64'(e.res));
            end
        end
    endtask

    task automatic pulse_flush();
        wrong_commit = 1'b1;
        tick();
        wrong_commit = 1'b0;
    endtask

    initial begin
        // Rows start with empty queues; priority carries row to row (ALU first after reset).
        vecs[0] = '{1'b1, 5'd3,  32'h11,   1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'h11, 3'd0, 1'b0, 5'd3,  32'h11};
        vecs[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h22, 1'b1, 5'd9,  32'h22, 3'd0, 1'b0, 5'd9,  32'h22};
        vecs[2] = '{1'b1, 5'd4,  32'h44,   1'b1, 5'd7,  32'h77, 1'b1, 5'd4,  32'h44, 3'd1, 1'b1, 5'd7,  32'h77};
        vecs[3] = '{1'b1, 5'd5,  32'h55,   1'b1, 5'd6,  32'h66, 1'b1, 5'd5,  32'h55, 3'd1, 1'b1, 5'd6,  32'h66};
        vecs[4] = '{1'b1, 5'd0,  32'hdead, 1'b1, 5'd8,  32'h88, 1'b1, 5'd8,  32'h88, 3'd0, 1'b0, 5'd8,  32'h88};
        vecs[5] = '{1'b1, 5'd0,  32'hbeef, 1'b0, 5'd0,  32'h0,  1'b0, 5'd8,  32'h88, 3'd0, 1'b0, 5'd8,  32'h88};
        vecs[6] = '{1'b1, 5'd10, 32'haa,   1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'haa, 3'd0, 1'b0, 5'd10, 32'haa};
        vecs[7] = '{1'b1, 5'd11, 32'hbb,   1'b1, 5'd12, 32'hcc, 1'b1, 5'd12, 32'hcc, 3'd0, 1'b1, 5'd11, 32'hbb};

        rst = 1'b1;
        rdy = 1'b1;
        wrong_commit = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_res", 64'(cdb_res), 64'd0);
        check("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);
        check("rst_alu_stall", 64'(alu_stall), 64'd0);
        check("rst_lsb_stall", 64'(lsb_stall), 64'd0);

        // Table: one offer cycle, then one idle cycle that drains any loser.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].av, int'(vecs[i].aid), vecs[i].ares, vecs[i].lv, int'(vecs[i].lid), vecs[i].lres);
            tick();
            check($sformatf("v%0d_c1_valid", i), 64'(cdb_valid), 64'(vecs[i].e1v));
            check($sformatf("v%0d_c1_id", i), 64'(cdb_rob_id), 64'(vecs[i].e1id));
            check($sformatf("v%0d_c1_res", i), 64'(cdb_res), 64'(vecs[i].e1res));
            check($sformatf("v%0d_c1_lsb_cnt", i), 64'(dut.lsb_count), 64'(vecs[i].e1lc));
            check($sformatf("v%0d_c1_stall", i), 64'({alu_stall, lsb_stall}), 64'd0);
            idle();
            tick();
            check($sformatf("v%0d_c2_valid", i), 64'(cdb_valid), 64'(vecs[i].e2v));
            check($sformatf("v%0d_c2_id", i), 64'(cdb_rob_id), 64'(vecs[i].e2id));
            check($sformatf("v%0d_c2_res", i), 64'(cdb_res), 64'(vecs[i].e2res));
            check($sformatf("v%0d_c2_lsb_cnt", i), 64'(dut.lsb_count), 64'd0);
        end

        // Sustained contention, then LSB alone pushing into a full queue (id 25 is dropped).
        pulse_flush();
        for (int k = 1; k <= 6; k++) begin
            expect_bcast(k, a_res(k));
            expect_bcast(16 + k, l_res(k));
        end
        expect_bcast(23, l_res(7));
        expect_bcast(24, l_res(8));
        for (int e = 1; e <= 9; e++) begin
            drive(e <= 6, e, a_res(e), 1'b1, 16 + e, l_res(e));
            tick();
            observe($sformatf("cont_e%0d", e));
            if (e == 5) begin
                check("cont_e5_lsb_stall", 64'(lsb_stall), 64'd1);
                check("cont_e5_alu_stall", 64'(alu_stall), 64'd0);
            end
            if (e == 6) check("cont_e6_alu_stall", 64'(alu_stall), 64'd1);
            if (e == 7) check("cont_e7_lsb_cnt", 64'(dut.lsb_count), 64'd4);
            if (e == 8) check("cont_e8_overflow", 64'(overflow_err), 64'd0);
            if (e == 9) check("cont_e9_overflow", 64'(overflow_err), 64'd1);
        end
        idle();
        for (int e = 10; e <= 15; e++) begin
            tick();
            observe($sformatf("drain_e%0d", e));
        end
        check("drain_cdb_valid", 64'(cdb_valid), 64'd0);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        // Flush with three entries queued per source; offers on the flush edge are ignored.
        pulse_flush();
        for (int k = 1; k <= 3; k++) begin
            expect_bcast(k, a_res(k));
            expect_bcast(16 + k, l_res(k));
        end
        for (int e = 1; e <= 6; e++) begin
            drive(1'b1, e, a_res(e), 1'b1, 16 + e, l_res(e));
            tick();
            observe($sformatf("fl_e%0d", e));
        end
        check("fl_pre_alu_cnt", 64'(dut.alu_count), 64'd3);
        check("fl_pre_lsb_cnt", 64'(dut.lsb_count), 64'd3);
        drive(1'b1, 7, a_res(7), 1'b1, 23, l_res(7));
        wrong_commit = 1'b1;
        tick();
        wrong_commit = 1'b0;
        idle();
        check("fl_cdb_valid", 64'(cdb_valid), 64'd0);
        check("fl_alu_cnt", 64'(dut.alu_count), 64'd0);
        check("fl_lsb_cnt", 64'(dut.lsb_count), 64'd0);
        check("fl_stalls", 64'({alu_stall, lsb_stall}), 64'd0);
        check("fl_overflow_kept", 64'(overflow_err), 64'd1);
        tick();
        check("fl_after_valid", 64'(cdb_valid), 64'd0);
        check("fl_sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        // rdy low freezes everything; an id-0 offer afterwards is discarded.
        expect_bcast(1, a_res(1));
        expect_bcast(17, l_res(1));
        expect_bcast(2, a_res(2));
        expect_bcast(18, l_res(2));
        for (int e = 1; e <= 2; e++) begin
            drive(1'b1, e, a_res(e), 1'b1, 16 + e, l_res(e));
            tick();
            observe($sformatf("hold_e%0d", e));
        end
        rdy = 1'b0;
        drive(1'b1, 5, a_res(5), 1'b1, 20, l_res(4));
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold%0d_valid", c), 64'(cdb_valid), 64'd1);
            check($sformatf("hold%0d_id", c), 64'(cdb_rob_id), 64'd17);
            check($sformatf("hold%0d_res", c), 64'(cdb_res), 64'(l_res(1)));
            check($sformatf("hold%0d_alu_cnt", c), 64'(dut.alu_count), 64'd1);
            check($sformatf("hold%0d_lsb_cnt", c), 64'(dut.lsb_count), 64'd1);
        end
        rdy = 1'b1;
        drive(1'b1, 0, 32'h1234, 1'b0, 0, '0);
        tick();
        observe("hold_rel1");
        idle();
        tick();
        observe("hold_rel2");
        tick();
        check("hold_end_valid", 64'(cdb_valid), 64'd0);
        check("hold_sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        // Reset mid-contention, with rdy low, wins and discards queued work.
        for (int e = 1; e <= 3; e++) begin
            drive(1'b1, e, a_res(e), 1'b1, 16 + e, l_res(e));
            tick();
        end
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        check("rst2_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst2_cdb_id", 64'(cdb_rob_id), 64'd0);
        check("rst2_cdb_res", 64'(cdb_res), 64'd0);
        check("rst2_overflow", 64'(overflow_err), 64'd0);
        check("rst2_cnts", 64'({dut.alu_count, dut.lsb_count}), 64'd0);
        check("rst2_stalls", 64'({alu_stall, lsb_stall}), 64'd0);
        tick();
        check("rst2_idle_valid", 64'(cdb_valid), 64'd0);
        drive(1'b1, 3, a_res(3), 1'b1, 19, l_res(3));
        tick();
        check("rst2_prio_id", 64'(cdb_rob_id), 64'd3);
        idle();
        tick();
        check("rst2_second_id", 64'(cdb_rob_id), 64'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the entries per source result queue (power of two, >=2).
REQ-002 Parameter ROB_W, default 5, SHALL set the ROB id width; id 0 means "no entry".
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rdy  input  1  global enable; when low, all state and outputs SHALL hold.
REQ-006 wrong_commit  input  1  misprediction flush.
REQ-007 alu_valid / alu_res / alu_rob_id  input  1/32/ROB_W  ALU result offer.
REQ-008 lsb_valid / lsb_res / lsb_rob_id  input  1/32/ROB_W  LSB result offer.
REQ-009 alu_stall / lsb_stall  output  1/1  per-source back-pressure, combinational from queue count.
REQ-010 cdb_valid / cdb_res / cdb_rob_id  output  1/32/ROB_W  registered common-data-bus broadcast.
REQ-011 overflow_err  output  1  sticky; a push was dropped because its queue was full.

Function
REQ-012 The block SHALL broadcast at most one result per enabled cycle.
REQ-013 Per source, candidate = queue head if the queue is non-empty, else the live input if valid and rob_id != 0.
REQ-014 Offers with rob_id == 0 SHALL be discarded: never queued, never broadcast.
REQ-015 Only one candidate present: that candidate SHALL win.
REQ-016 Both present: round-robin; a 1-bit last_grant register SHALL give priority to the source not granted last, initial priority ALU.
REQ-017 last_grant SHALL update only on a cycle with a grant.
REQ-018 Winner SHALL be loaded into cdb_* at the same edge the offer is sampled (bypass when queue empty), so latency is 0 extra cycles for an uncontended empty-queue source.
REQ-019 Winner from queue head: head SHALL pop; a simultaneous valid live input of that source SHALL push the same edge.
REQ-020 A valid live input that is not the winner SHALL push to its queue, preserving per-source order.
REQ-021 No grant in an enabled cycle: cdb_valid SHALL be 0 on the next cycle; cdb_res/cdb_rob_id SHALL hold.
REQ-022 x_stall SHALL be 1 when that queue count >= DEPTH-1.
REQ-023 Push to a full queue with no same-edge pop: the offer SHALL be dropped and overflow_err set until rst.
REQ-024 Queue count SHALL be width clog2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-025 wrong_commit (rdy high or low) SHALL empty both queues, clear cdb_valid, reset last_grant to ALU-priority, and ignore same-cycle offers; overflow_err SHALL be kept.

Reset
REQ-026 rst SHALL take precedence over rdy and wrong_commit.
REQ-027 On rst: cdb_valid=0, cdb_res=0, cdb_rob_id=0, overflow_err=0, queues empty, last_grant=ALU-priority.
REQ-028 After rst: alu_stall=lsb_stall=0 in the following cycle.
REQ-029 rst mid-contention SHALL discard all queued results.

Structure
REQ-030 DEPTH default, ROB_W and the 32-bit data width SHALL live in the shared constants include.
REQ-031 The per-source queue SHALL be one sub-module, cdb_fifo (push, pop, flush, head, count, full), instantiated twice.
REQ-032 Arbitration and output registers SHALL be in cdb_arbiter; no other sub-modules.

Verification
REQ-033 ALU only: alu_valid=1, id=3, res=0x11 -> next cycle cdb_valid=1, cdb_rob_id=3, cdb_res=0x11; no stall.
REQ-034 Simultaneous: ALU id=4 and LSB id=7 at reset priority -> cdb id 4, then id 7 the next cycle; LSB queue count 1 then 0.
REQ-035 Sustained contention for 6 cycles -> grants alternate strictly ALU/LSB; per-source ids leave in issue order.
REQ-036 LSB held off by ALU until LSB queue reaches 3 (DEPTH=4) -> lsb_stall=1; a forced push at full -> overflow_err=1, dropped id never broadcast.
REQ-037 Queues holding 3 entries, wrong_commit pulse -> next cycle cdb_valid=0, counts 0, stalls 0, overflow_err unchanged.
REQ-038 rdy=0 for 3 cycles with queued results -> cdb_* and counts frozen; alu_valid=1, id=0 -> nothing queued or broadcast.
